// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (slave) and its datapath (master).
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_type;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;

    modport master (
        output opcode, mem_ready, branch_taken,
        input  state, mem_req, mem_we, ir_we, reg_we, pc_we,
        input  pc_sel, imm_type, wb_sel, illegal, bus_err
    );

    modport slave (
        input  opcode, mem_ready, branch_taken,
        output state, mem_req, mem_we, ir_we, reg_we, pc_we,
        output pc_sel, imm_type, wb_sel, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define CTRL_TIMEOUT_EN to bound memory waits by TIMEOUT_CYCLES and raise bus_err.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic             clk,
    input logic             rst_n,
    multicycle_ctrl_if.slave ctrl
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic supported(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: supported = 1'b1;
            default:                          supported = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: imm_of = 3'd1;
            OP_STORE:                 imm_of = 3'd2;
            OP_BRANCH:                imm_of = 3'd3;
            OP_LUI, OP_AUIPC:         imm_of = 3'd4;
            OP_JAL:                   imm_of = 3'd5;
            default:                  imm_of = 3'd0;
        endcase
    endfunction

    logic [2:0] state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    logic       mem_req_c, mem_we_c, ir_we_c, reg_we_c, pc_we_c;
    logic [1:0] pc_sel_c, wb_sel_c;
    logic [2:0] imm_c;

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          waiting, timeout;

    // Counts consecutive stalled request cycles; any non-stalled cycle restarts it.
    assign waiting    = mem_req_c && !ctrl.mem_ready;
    assign wait_cnt_d = waiting ? wait_cnt_q + CW'(1) : '0;
    assign timeout    = waiting && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus_err_d  = bus_err_q | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign ctrl.bus_err = bus_err_q;
`else
    assign ctrl.bus_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = ctrl.opcode;
                if (supported(ctrl.opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH)                         state_d = S_FETCH;
                else if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
                else                                           state_d = S_WB;
            end
            S_MEM:    if (ctrl.mem_ready) state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
`ifdef CTRL_TIMEOUT_EN
        if (timeout) state_d = S_TRAP;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are gated by rst_n so an asserted reset silences them within the cycle.
    always_comb begin
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        pc_we_c   = 1'b0;
        pc_sel_c  = 2'd0;
        imm_c     = 3'd0;
        wb_sel_c  = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_c = 1'b1;
                    ir_we_c   = ctrl.mem_ready;
                end
                S_DECODE: imm_c = imm_of(ctrl.opcode);
                S_EXEC: begin
                    imm_c = imm_of(op_q);
                    if (op_q == OP_BRANCH) begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = ctrl.branch_taken ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    mem_req_c = 1'b1;
                    mem_we_c  = (op_q == OP_STORE);
                    pc_we_c   = (op_q == OP_STORE) && ctrl.mem_ready;
                end
                S_WB: begin
                    reg_we_c = 1'b1;
                    pc_we_c  = 1'b1;
                    if (op_q == OP_JAL)       pc_sel_c = 2'd1;
                    else if (op_q == OP_JALR) pc_sel_c = 2'd2;
                    if (op_q == OP_LOAD)                        wb_sel_c = 2'd1;
                    else if (op_q == OP_JAL || op_q == OP_JALR) wb_sel_c = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign ctrl.state    = state_q;
    assign ctrl.mem_req  = mem_req_c;
    assign ctrl.mem_we   = mem_we_c;
    assign ctrl.ir_we    = ir_we_c;
    assign ctrl.reg_we   = reg_we_c;
    assign ctrl.pc_we    = pc_we_c;
    assign ctrl.pc_sel   = pc_sel_c;
    assign ctrl.imm_type = imm_c;
    assign ctrl.wb_sel   = wb_sel_c;
    assign ctrl.illegal  = illegal_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues per-cycle expectations, a monitor checks them.
module tb_multicycle_ctrl;
    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
    localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BAD = 7'b1111111;
    // strobe vectors {mem_req, mem_we, ir_we, reg_we, pc_we}
    localparam logic [4:0] NONE = 5'b00000, REQ = 5'b10000, REQIR = 5'b10100;
    localparam logic [4:0] WBS = 5'b00011, PCW = 5'b00001, STM = 5'b11001;

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] strb;
        logic [1:0] psel;
        logic [2:0] imm;
        logic [1:0] wsel;
        logic       ill;
        logic       berr;
    } obs_t;

    typedef struct {
        obs_t       o;
        logic [2:0] chk;  // compare {pc_sel, imm_type, wb_sel}
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   nvec = 0;
    exp_t expq[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [6:0] op, input logic mr, input logic bt,
                        input logic [2:0] st, input logic [4:0] strb, input logic [2:0] chk,
                        input logic [1:0] psel, input logic [2:0] imm, input logic [1:0] wsel,
                        input logic ill, input logic berr);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rst;
        bus.opcode       = op;
        bus.mem_ready    = mr;
        bus.branch_taken = bt;
        e.o.st   = st;
        e.o.strb = strb;
        e.o.psel = psel;
        e.o.imm  = imm;
        e.o.wsel = wsel;
        e.o.ill  = ill;
        e.o.berr = berr;
        e.chk    = chk;
        e.id     = nvec;
        nvec++;
        expq.push_back(e);
    endtask

    task automatic plain(input logic [6:0] op, input logic mr, input logic bt,
                         input logic [2:0] st, input logic [4:0] strb);
        step(1'b1, op, mr, bt, st, strb, 3'b000, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic sel(input logic [6:0] op, input logic mr, input logic bt,
                       input logic [2:0] st, input logic [4:0] strb, input logic [2:0] chk,
                       input logic [1:0] psel, input logic [2:0] imm, input logic [1:0] wsel);
        step(1'b1, op, mr, bt, st, strb, chk, psel, imm, wsel, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle(input logic ill, input logic berr);
        step(1'b0, ADDI, 1'b0, 1'b0, F, NONE, 3'b111, 2'd0, 3'd0, 2'd0, ill, berr);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        obs_t a, x;
        if (expq.size() != 0) begin
            e      = expq.pop_front();
            x      = e.o;
            a.st   = bus.state;
            a.strb = {bus.mem_req, bus.mem_we, bus.ir_we, bus.reg_we, bus.pc_we};
            a.psel = bus.pc_sel;
            a.imm  = bus.imm_type;
            a.wsel = bus.wb_sel;
            a.ill  = bus.illegal;
            a.berr = bus.bus_err;
            if (!e.chk[2]) begin a.psel = '0; x.psel = '0; end
            if (!e.chk[1]) begin a.imm  = '0; x.imm  = '0; end
            if (!e.chk[0]) begin a.wsel = '0; x.wsel = '0; end
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d strb=%b psel=%0d imm=%0d wsel=%0d ill=%b berr=%b, want st=%0d strb=%b psel=%0d imm=%0d wsel=%0d ill=%b berr=%b",
                         e.id, a.st, a.strb, a.psel, a.imm, a.wsel, a.ill, a.berr,
                         x.st, x.strb, x.psel, x.imm, x.wsel, x.ill, x.berr);
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        bus.opcode       = '0;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;

        rst_cycle(1'b0, 1'b0);
        rst_cycle(1'b0, 1'b0);

        // addi: F D E W, mem_ready high throughout
        plain(ADDI, 1, 0, F, REQIR);
        sel  (ADDI, 1, 0, D, NONE, 3'b010, 2'd0, 3'd1, 2'd0);
        plain(ADDI, 1, 0, E, NONE);
        sel  (ADDI, 1, 0, W, WBS, 3'b101, 2'd0, 3'd0, 2'd0);

        // lw with three wait cycles in MEM: 8 cycles total
        plain(LW, 1, 0, F, REQIR);
        sel  (LW, 1, 0, D, NONE, 3'b010, 2'd0, 3'd1, 2'd0);
        plain(LW, 0, 0, E, NONE);
        for (int i = 0; i < 3; i++) plain(LW, 0, 0, M, REQ);
        plain(LW, 1, 0, M, REQ);
        sel  (LW, 1, 0, W, WBS, 3'b101, 2'd0, 3'd0, 2'd1);

        // sw, zero wait, with a 2-cycle fetch stall first
        plain(SW, 0, 0, F, REQ);
        plain(SW, 0, 0, F, REQ);
        plain(SW, 1, 0, F, REQIR);
        sel  (SW, 1, 0, D, NONE, 3'b010, 2'd0, 3'd2, 2'd0);
        plain(SW, 1, 0, E, NONE);
        plain(SW, 1, 0, M, STM);

        // beq taken then not taken
        plain(BEQ, 1, 1, F, REQIR);
        sel  (BEQ, 1, 1, D, NONE, 3'b010, 2'd0, 3'd3, 2'd0);
        sel  (BEQ, 1, 1, E, PCW, 3'b100, 2'd1, 3'd0, 2'd0);
        plain(BEQ, 1, 0, F, REQIR);
        sel  (BEQ, 1, 0, D, NONE, 3'b010, 2'd0, 3'd3, 2'd0);
        sel  (BEQ, 1, 0, E, PCW, 3'b100, 2'd0, 3'd0, 2'd0);

        // lui
        plain(LUI, 1, 0, F, REQIR);
        sel  (LUI, 1, 0, D, NONE, 3'b010, 2'd0, 3'd4, 2'd0);
        plain(LUI, 1, 0, E, NONE);
        sel  (LUI, 1, 0, W, WBS, 3'b101, 2'd0, 3'd0, 2'd0);

        // jalr
        plain(JALR, 1, 0, F, REQIR);
        sel  (JALR, 1, 0, D, NONE, 3'b010, 2'd0, 3'd1, 2'd0);
        plain(JALR, 1, 0, E, NONE);
        sel  (JALR, 1, 0, W, WBS, 3'b101, 2'd2, 3'd0, 2'd2);

        // jal
        plain(JAL, 1, 0, F, REQIR);
        sel  (JAL, 1, 0, D, NONE, 3'b010, 2'd0, 3'd5, 2'd0);
        plain(JAL, 1, 0, E, NONE);
        sel  (JAL, 1, 0, W, WBS, 3'b101, 2'd1, 3'd0, 2'd2);

        // jal with reset pulsed during WB
        plain(JAL, 1, 0, F, REQIR);
        sel  (JAL, 1, 0, D, NONE, 3'b010, 2'd0, 3'd5, 2'd0);
        plain(JAL, 1, 0, E, NONE);
        rst_cycle(1'b0, 1'b0);
        plain(JAL, 0, 0, F, REQ);
        plain(ADDI, 1, 0, F, REQIR);
        sel  (ADDI, 1, 0, D, NONE, 3'b010, 2'd0, 3'd1, 2'd0);
        plain(ADDI, 1, 0, E, NONE);
        sel  (ADDI, 1, 0, W, WBS, 3'b101, 2'd0, 3'd0, 2'd0);

        // memory never answers in FETCH
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) plain(ADDI, 0, 0, F, REQ);
        step(1'b1, ADDI, 1'b0, 1'b0, T, NONE, 3'b000, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
        step(1'b1, ADDI, 1'b1, 1'b0, T, NONE, 3'b000, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
`else
        for (int i = 0; i < 100; i++) plain(ADDI, 0, 0, F, REQ);
`endif
        rst_cycle(1'b0, 1'b0);

        // unsupported opcode traps after DECODE and stays there
        plain(BAD, 1, 0, F, REQIR);
        plain(BAD, 1, 0, D, NONE);
        for (int i = 0; i < 20; i++)
            step(1'b1, BAD, 1'(i & 1), 1'b1, T, NONE, 3'b111, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0);
        rst_cycle(1'b0, 1'b0);
        plain(ADDI, 0, 0, F, REQ);

        repeat (3) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
